// File: rtl/divider_pkg.sv
// ============================================================================
//  Module      : divider_pkg
//  Description : Shared definitions for the approximate-divider accuracy path.
//                Holds the datapath widths, the FSM state encoding and the
//                legal upper bound for the number of approximate adder bits.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package divider_pkg;

    localparam int DIV_W      = 8;   // quotient / divisor / remainder width
    localparam int ACC_W      = 16;  // reconstructed dividend width
    localparam int APPROX_MAX = 8;   // largest legal APPROX_BITS

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_mul_reconstruct_if.sv
// ============================================================================
//  Module      : seq_mul_reconstruct_if
//  Description : Operand/result handshake bundle for seq_mul_reconstruct.
//                master : producer/consumer side (drives operands, out_ready)
//                slave  : the reconstruct block itself
//  Ports       : in_valid/in_ready + q, y, r   operand channel
//                out_valid/out_ready + p        result channel
//                busy                           block is iterating
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_mul_reconstruct_if;
    import divider_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [DIV_W-1:0] q;
    logic [DIV_W-1:0] y;
    logic [DIV_W-1:0] r;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] p;
    logic             busy;

    modport master (
        output in_valid, q, y, r, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, q, y, r, out_ready,
        output in_ready, out_valid, p, busy
    );

endinterface

`default_nettype wire

// File: rtl/approx_add16.sv
// ============================================================================
//  Module      : approx_add16
//  Description : Combinational 16-bit adder whose low APPROX_BITS positions
//                are replaced by a bitwise OR. No carry leaves the OR region,
//                so the upper slice adds with carry-in 0. Carry out of the
//                top bit is discarded.
//  Ports       : i_a, i_b  addends
//                o_sum     approximate sum
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module approx_add16
    import divider_pkg::*;
#(
    parameter int unsigned APPROX_BITS = 0
) (
    input  wire logic [ACC_W-1:0] i_a,
    input  wire logic [ACC_W-1:0] i_b,
    output logic      [ACC_W-1:0] o_sum
);

    generate
        if (APPROX_BITS == 0) begin : g_exact
            assign o_sum = i_a + i_b;
        end else begin : g_approx
            assign o_sum[APPROX_BITS-1:0] = i_a[APPROX_BITS-1:0] | i_b[APPROX_BITS-1:0];
            assign o_sum[ACC_W-1:APPROX_BITS] = i_a[ACC_W-1:APPROX_BITS]
                                              + i_b[ACC_W-1:APPROX_BITS];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/seq_mul_reconstruct.sv
// ============================================================================
//  Module      : seq_mul_reconstruct
//  Description : Sequential shift-add multiply-accumulate, p = q*y + r.
//                Rebuilds the dividend from divider outputs so the divider
//                error can be measured. One multiplier bit is consumed per
//                cycle over 8 BUSY cycles; the accumulator starts at r.
//  Ports       : clk    rising-edge clock
//                rst_n  synchronous active-low reset
//                bus    seq_mul_reconstruct_if.slave (operands, result, busy)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_mul_reconstruct
    import divider_pkg::*;
#(
    parameter int unsigned APPROX_BITS = 0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    seq_mul_reconstruct_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE = ST_IDLE;
    localparam logic [1:0] c_ST_BUSY = ST_BUSY;
    localparam logic [1:0] c_ST_DONE = ST_DONE;

    generate
        if (APPROX_BITS > APPROX_MAX) begin : g_bad_approx_bits
            $error("seq_mul_reconstruct: APPROX_BITS must be in 0..8");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [2:0]       r_count;
    logic [DIV_W-1:0] r_q;
    logic [DIV_W-1:0] r_y;
    logic [ACC_W-1:0] r_acc;

    logic [ACC_W-1:0] w_addend;
    logic [ACC_W-1:0] w_sum;

    // Partial product for the current multiplier bit.
    assign w_addend = {{(ACC_W-DIV_W){1'b0}}, r_y} << r_count;

    approx_add16 #(
        .APPROX_BITS (APPROX_BITS)
    ) u_add (
        .i_a   (r_acc),
        .i_b   (w_addend),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_count <= 3'd0;
            r_q     <= '0;
            r_y     <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_q     <= bus.q;
                        r_y     <= bus.y;
                        r_acc   <= {{(ACC_W-DIV_W){1'b0}}, bus.r};
                        r_count <= 3'd0;
                        r_state <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (r_q[r_count]) begin
                        r_acc <= w_sum;
                    end
                    r_count <= r_count + 3'd1;
                    if (r_count == 3'd7) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    // Return to IDLE only; the next accept needs a full
                    // cycle with in_ready high.
                    if (bus.out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == c_ST_IDLE);
    assign bus.busy      = (r_state == c_ST_BUSY);
    assign bus.out_valid = (r_state == c_ST_DONE);
    assign bus.p         = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_seq_mul_reconstruct.sv
// ============================================================================
//  Module      : tb_seq_mul_reconstruct
//  Description : Self-checking bench. Two instances (APPROX_BITS = 0 and 4)
//                receive identical stimulus; the exact one is compared with
//                q*y+r, the approximate one with hand values or with a
//                stepwise model built on approx_add16.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_mul_reconstruct;

    localparam int c_N_B2B = 100;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] q;
    logic [7:0] y;
    logic [7:0] r;

    int n_checks;
    int n_errors;
    int cyc;

    seq_mul_reconstruct_if if0 ();
    seq_mul_reconstruct_if if4 ();

    assign if0.in_valid  = in_valid;
    assign if0.out_ready = out_ready;
    assign if0.q         = q;
    assign if0.y         = y;
    assign if0.r         = r;
    assign if4.in_valid  = in_valid;
    assign if4.out_ready = out_ready;
    assign if4.q         = q;
    assign if4.y         = y;
    assign if4.r         = r;

    seq_mul_reconstruct #(.APPROX_BITS(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    seq_mul_reconstruct #(.APPROX_BITS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    // Reference adder for the APPROX_BITS=4 model.
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [15:0] m_sum;
    approx_add16 #(.APPROX_BITS(4)) u_ref (.i_a(m_a), .i_b(m_b), .o_sum(m_sum));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Steps the reference adder through the 8 shift-add iterations.
    task automatic model4(input logic [7:0] mq, input logic [7:0] my,
                          input logic [7:0] mr, output logic [15:0] res);
        logic [15:0] acc;
        acc = {8'h00, mr};
        for (int i = 0; i < 8; i++) begin
            if (mq[i]) begin
                m_a = acc;
                m_b = {8'h00, my} << i;
                #1;
                acc = m_sum;
            end
        end
        res = acc;
    endtask

    // One transaction with latency measurement and a single-cycle consume.
    task automatic run_txn(input string tag, input logic [7:0] tq, input logic [7:0] ty,
                           input logic [7:0] tr, input logic [15:0] e0, input logic [15:0] e4);
        int n;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(if0.in_ready), 32'd1);
        q = tq; y = ty; r = tr;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        q = ~tq; y = ~ty; r = ~tr;
        check({tag, "_busy"}, 32'(if0.busy), 32'd1);
        n = 0;
        while (!if0.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 8);
        check({tag, "_p0"}, 32'(if0.p), 32'(e0));
        check({tag, "_p4"}, 32'(if4.p), 32'(e4));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_done_ovalid"}, 32'(if0.out_valid), 32'd0);
        check({tag, "_done_iready"}, 32'(if0.in_ready), 32'd1);
    endtask

    logic [7:0]  bq [c_N_B2B];
    logic [7:0]  by [c_N_B2B];
    logic [7:0]  br [c_N_B2B];
    logic [15:0] be4 [c_N_B2B];
    logic [15:0] e4;
    logic [15:0] e0;
    int          n;
    int          prev;
    int          seen;
    logic        stable;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        q = '0; y = '0; r = '0;
        m_a = '0; m_b = '0;

        for (int k = 0; k < c_N_B2B; k++) begin
            bq[k] = 8'($urandom);
            by[k] = 8'($urandom);
            br[k] = 8'($urandom);
            model4(bq[k], by[k], br[k], be4[k]);
        end

        @(negedge clk);
        check("rst_in_ready", 32'(if0.in_ready), 32'd1);
        check("rst_out_valid", 32'(if0.out_valid), 32'd0);
        check("rst_busy", 32'(if0.busy), 32'd0);
        check("rst_p0", 32'(if0.p), 32'h0);
        check("rst_p4", 32'(if4.p), 32'h0);
        rst_n = 1'b1;

        model4(8'hFF, 8'hFF, 8'hFF, e4);
        run_txn("full", 8'hFF, 8'hFF, 8'hFF, 16'hFF00, e4);
        run_txn("zero_q", 8'h00, 8'hAB, 8'h3C, 16'h003C, 16'h003C);
        run_txn("msb_q", 8'h80, 8'h01, 8'h00, 16'h0080, 16'h0080);
        run_txn("approx", 8'h01, 8'h0F, 8'h01, 16'h0010, 16'h000F);

        // Backpressure: 3*5+2 = 0x11; approx: 2|5=7, then 7|0xA=0xF.
        @(negedge clk);
        q = 8'h03; y = 8'h05; r = 8'h02; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!if0.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach_done", 32'(if0.out_valid), 32'd1);
        in_valid = 1'b1; q = 8'hFF; y = 8'hFF; r = 8'hFF;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (if0.p !== 16'h0011 || if4.p !== 16'h000F || if0.out_valid !== 1'b1 || if0.in_ready !== 1'b0)
                stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_p0", 32'(if0.p), 32'h0011);
        check("bp_p4", 32'(if4.p), 32'h000F);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_after_ovalid", 32'(if0.out_valid), 32'd0);
        check("bp_after_iready", 32'(if0.in_ready), 32'd1);
        check("bp_idle_hold_p", 32'(if0.p), 32'h0011);

        // Reset while BUSY with count=4.
        @(negedge clk);
        q = 8'hFF; y = 8'hFF; r = 8'hFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", 32'(if0.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_p", 32'(if0.p), 32'h0);
        check("mid_rst_ovalid", 32'(if0.out_valid), 32'd0);
        check("mid_rst_iready", 32'(if0.in_ready), 32'd1);
        check("mid_rst_busy", 32'(if0.busy), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (if0.out_valid || if4.out_valid) seen++;
        end
        check("mid_rst_no_stale", seen, 0);

        // Back-to-back with in_valid and out_ready held high.
        in_valid = 1'b1; out_ready = 1'b1; prev = 0;
        for (int k = 0; k < c_N_B2B; k++) begin
            q = bq[k]; y = by[k]; r = br[k];
            n = 0;
            while (!if0.in_ready && n < 30) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            if (k == c_N_B2B - 1) in_valid = 1'b0;
            if (k > 0) check("b2b_ii", cyc - prev, 10);
            prev = cyc;
            n = 0;
            while (!if0.out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            e0 = {8'h00, bq[k]} * {8'h00, by[k]} + {8'h00, br[k]};
            check("b2b_p0", 32'(if0.p), 32'(e0));
            check("b2b_p4", 32'(if4.p), 32'(be4[k]));
            @(negedge clk);
        end
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_mul_reconstruct.md
# seq_mul_reconstruct

Sequential shift-add multiply-accumulate that rebuilds a dividend from array-divider outputs, computing p = q·y + r. It is the inverse-direction companion to the 16/8 approximate array divider: it takes the divider's quotient, divisor and remainder and returns the 16-bit product-plus-remainder for error measurement. The adder can replicate the divider's approximation style on its low bit positions. It sits downstream of the divider in the accuracy-evaluation datapath and uses a valid/ready handshake on both sides.

## Interface
- APPROX_BITS, default 0: number of accumulator LSB positions (0..8) computed as OR, with no carry out of the approximate region.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands; high only in IDLE.
- q  in  8  quotient (multiplier).
- y  in  8  divisor (multiplicand).
- r  in  8  remainder (initial accumulator value).
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- p  out  16  result q·y + r, with approximate low bits when APPROX_BITS > 0.
- busy  out  1  high in BUSY.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, go to BUSY.
  - BUSY: count 0..7. Go to DONE when the step with count=7 completes.
  - DONE: out_valid=1. On out_valid && out_ready, go to IDLE.
- Accept edge:
  - Register q and y.
  - acc ← {8'h00, r}.
  - count ← 0.
- BUSY step i = count:
  - If q_reg[i]=1, acc ← approx_add(acc, {8'h00, y_reg} << i). Otherwise acc is unchanged.
  - count ← count+1.
- approx_add(a, b), 16 bits:
  - Bits [APPROX_BITS-1:0] = a | b.
  - Bits [15:APPROX_BITS] = a[15:APPROX_BITS] + b[15:APPROX_BITS], with carry-in 0.
  - Any carry out of bit 15 is discarded. It cannot occur when APPROX_BITS=0, since the maximum exact value is 255·255+255 = 0xFF00.
- p is driven directly from acc. It is stable for the whole of DONE and holds its last value in IDLE.
- in_ready is low in BUSY and DONE. The block never accepts a new operand in the same cycle a result is consumed.
- in_valid in BUSY or DONE is ignored. q, y and r may change freely after acceptance.
- APPROX_BITS outside 0..8 is a compile-time error (elaboration assertion).

## Timing
- Reset values (rst_n=0 sampled at an edge):
  - State = IDLE, acc = 0, count = 0.
  - in_ready=1, out_valid=0, busy=0, p=16'h0000.
- Reset mid-operation (BUSY or DONE): return to IDLE at that edge. The pending result is dropped and out_valid is never asserted for it.
- Latency: with acceptance at edge E0, BUSY covers E1..E8 and out_valid=1 after E8. That is 8 cycles from acceptance to valid.
- Backpressure: DONE is held indefinitely while out_ready=0. p and out_valid do not change.
- Minimum initiation interval is 10 cycles:
  - accept at E0;
  - consume at E9 with out_ready held high;
  - in_ready is high after E9;
  - the next accept is at E10.
- No combinational path from inputs to outputs. in_ready, out_valid and busy are decoded from registered state only.

## Structure
- Shared package `divider_pkg`:
  - state enum {IDLE, BUSY, DONE};
  - localparams DIV_W=8 and ACC_W=16;
  - the APPROX_BITS range limit.
- Sub-module `approx_add16`: combinational, parameterised by APPROX_BITS, implements approx_add. It is instantiated once in the accumulate path and reused by the bench reference model.
- Top level holds the FSM, the 3-bit count, operand registers and the accumulator.

## Test plan
- Full-scale, APPROX_BITS=0: q=0xFF, y=0xFF, r=0xFF, out_ready=1 -> p=0xFF00; out_valid rises exactly 8 cycles after acceptance.
- Zero quotient: q=0x00, y=0xAB, r=0x3C -> p=0x003C. Then q=0x80, y=0x01, r=0 -> p=0x0080.
- Approximation, APPROX_BITS=4: q=0x01, y=0x0F, r=0x01 -> p=0x000F (exact answer would be 0x0010). A random sweep matches the approx_add16 reference model bit-exactly.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> p and out_valid are stable, in_ready=0, and a concurrent in_valid is ignored. Then raise out_ready -> one transfer, and in_ready is high the next cycle.
- Reset mid-operation: assert rst_n=0 at count=4 -> after that edge: IDLE, p=0, out_valid=0, in_ready=1. No stale result appears after reset is released.
- Back-to-back: 100 random transactions with in_valid and out_ready held high -> initiation interval is 10 cycles, and all results match q·y+r for APPROX_BITS=0.
